alu_ex_stage: RTL
=================

// Module: alu_ex_stage
// PURPOSE
//   Two-stage pipelined execute wrapper around the alu_riscv ALU. Accepts decoded ALU ops from the
//   decode/regfile stage on a valid/ready handshake, registers the operands (OP stage), evaluates them in
//   alu_riscv, and registers result/flag/destination tag (RES stage) for writeback/branch logic.
//   Full throughput of one op per cycle; backpressure propagates upstream.
// PARAMETERS
//   XLEN     32  operand/result width
//   RD_W     5   destination-register tag width
// PORTS
//   clk_i         in   1     clock, rising edge
//   rst_i         in   1     reset, asynchronous, active-high
//   flush_i       in   1     drop all in-flight ops (branch taken / trap)
//   in_valid_i    in   1     upstream op valid
//   in_ready_o    out  1     stage can accept op this cycle
//   alu_op_i      in   5     ALU opcode (alu_opcodes_pkg ALU_*)
//   a_i           in   XLEN  operand A
//   b_i           in   XLEN  operand B
//   rd_i          in   RD_W  destination tag, passed through untouched
//   out_valid_o   out  1     RES stage holds a valid op
//   out_ready_i   in   1     downstream consumes RES this cycle
//   out_result_o  out  XLEN  registered ALU result
//   out_flag_o    out  1     registered ALU comparison flag
//   out_rd_o      out  RD_W  registered destination tag
//   fwd_a_i       in   1     (ALU_FWD_EN only) replace A with previous op's result
//   fwd_b_i       in   1     (ALU_FWD_EN only) replace B with previous op's result
// BEHAVIOUR
//   - Reset: op_valid=0, res_valid=0, all OP/RES data registers 0; out_valid_o=0, out_result_o=0,
//     out_flag_o=0, out_rd_o=0. in_ready_o=1 once rst_i deasserts (unless flush_i).
//   - res_adv = !res_valid | out_ready_i;  op_adv = op_valid & res_adv.
//   - in_ready_o = !flush_i & (!op_valid | res_adv)  (combinational; no skid buffer).
//   - Accept (in_valid_i & in_ready_o): OP regs <= {alu_op_i,a_i,b_i,rd_i}, op_valid<=1.
//   - op_adv: RES regs <= {alu result_o, flag_o, OP rd}, res_valid<=1. No accept & op_adv: op_valid<=0.
//   - Out handshake without op_adv: res_valid<=0. RES data regs hold their value after drain.
//   - Latency: accept at edge N -> out_valid_o high after edge N+1 (2 edges from sample to output).
//   - Stall: out_ready_i=0 with res_valid=1 -> RES and OP frozen, in_ready_o=0 if op_valid.
//   - Simultaneous accept + op_adv + out handshake: all three occur same edge, no bubble.
//   - flush_i: next edge op_valid<=0, res_valid<=0; input in flush cycle is not accepted; out_valid_o
//     still visible in flush cycle but downstream must ignore it; data regs untouched.
//   - Flag/result encoding is exactly alu_riscv's: compute ops flag=0, branch ops result=0; no change here.
//   - Unknown opcode: whatever alu_riscv produces (result 0, flag 0); stage does not trap.
// CONFIGURATION
//   ALU_FWD_EN defined: fwd_a_i/fwd_b_i ports exist, sampled on accept. Forward value = alu result_o if
//     op_adv in the accept cycle (producer leaving OP), else RES result register (producer already
//     registered or drained). After flush/reset the source is the RES register (0 after reset).
//   ALU_FWD_EN undefined: ports absent, a_i/b_i always used verbatim.
// STRUCTURE
//   - alu_opcodes_pkg: ALU_* opcode localparams (existing) plus ALU_OP_W=5; import it here.
//   - One sub-module: alu_riscv instantiated between OP and RES registers; no other hierarchy.
// TESTING
//   1 Reset mid-stream: rst_i pulse with op in OP and RES -> out_valid_o=0, out_result_o=0 immediately.
//   2 ADD 0xAABB,0x00AA accepted edge N, out_ready_i=1 -> edge N+1 out_result_o=0x0000AB65, flag=0, rd kept.
//   3 Back-to-back SUB 0xAABB,0xAA / SUB 0xAA,0xAABB / SLL 0xAABB,10 -> 0xAA11, 0xFFFF55EF, 0x02AAEC00
//     on 3 consecutive cycles, in_ready_o constantly 1.
//   4 Stall: out_ready_i=0 for 4 cycles with 3 ops sent -> 2 held (RES, OP), in_ready_o=0, third held
//     upstream; release -> all three emerge in order, none lost/duplicated.
//   5 LTS 0xF000AABB,0xAA -> flag=1,result=0; EQ 0xAABB,0xAABB -> flag=1; flush_i with both stages full
//     -> out_valid_o=0 next cycle, in-cycle input not accepted.
//   6 (ALU_FWD_EN) ADD 1,2 then ADD fwd_a_i=1,b=5 back-to-back -> 3 then 8; same with 2-cycle gap -> 8.

Source files
------------

// File: rtl/alu_opcodes_pkg.sv
// ALU opcode constants shared by the decode stage, the execute stage and alu_riscv.
// Compute ops (0x00-0x0F) produce a result with flag=0; branch-compare ops (0x10-0x1F)
// produce a flag with result=0. Any unlisted code yields result=0, flag=0.
package alu_opcodes_pkg;

   localparam int ALU_OP_W = 5;

   // compute ops
   localparam logic [ALU_OP_W-1:0] ALU_ADD  = 5'h00;
   localparam logic [ALU_OP_W-1:0] ALU_SUB  = 5'h01;
   localparam logic [ALU_OP_W-1:0] ALU_SLL  = 5'h02;
   localparam logic [ALU_OP_W-1:0] ALU_SLT  = 5'h03;
   localparam logic [ALU_OP_W-1:0] ALU_SLTU = 5'h04;
   localparam logic [ALU_OP_W-1:0] ALU_XOR  = 5'h05;
   localparam logic [ALU_OP_W-1:0] ALU_SRL  = 5'h06;
   localparam logic [ALU_OP_W-1:0] ALU_SRA  = 5'h07;
   localparam logic [ALU_OP_W-1:0] ALU_OR   = 5'h08;
   localparam logic [ALU_OP_W-1:0] ALU_AND  = 5'h09;

   // branch-compare ops
   localparam logic [ALU_OP_W-1:0] ALU_EQ   = 5'h10;
   localparam logic [ALU_OP_W-1:0] ALU_NE   = 5'h11;
   localparam logic [ALU_OP_W-1:0] ALU_LTS  = 5'h12;
   localparam logic [ALU_OP_W-1:0] ALU_GES  = 5'h13;
   localparam logic [ALU_OP_W-1:0] ALU_LTU  = 5'h14;
   localparam logic [ALU_OP_W-1:0] ALU_GEU  = 5'h15;

endpackage

// File: rtl/alu_riscv.sv
// Purely combinational RISC-V integer ALU. Shift amount is the low log2(XLEN) bits of B.
module alu_riscv
   import alu_opcodes_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [ALU_OP_W-1:0] alu_op_i,
   input  logic [XLEN-1:0]     a_i,
   input  logic [XLEN-1:0]     b_i,
   output logic [XLEN-1:0]     result_o,
   output logic                flag_o
);

   localparam int SH_W = $clog2(XLEN);

   logic [SH_W-1:0] shamt;
   logic            lt_s;
   logic            lt_u;

   assign shamt = b_i[SH_W-1:0];
   assign lt_s  = $signed(a_i) < $signed(b_i);
   assign lt_u  = a_i < b_i;

   // opcode decode; unknown codes fall through to result 0, flag 0
   always_comb begin
      result_o = '0;
      flag_o   = 1'b0;
      case (alu_op_i)
         ALU_ADD:  result_o = a_i + b_i;
         ALU_SUB:  result_o = a_i - b_i;
         ALU_SLL:  result_o = a_i << shamt;
         ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_s};
         ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, lt_u};
         ALU_XOR:  result_o = a_i ^ b_i;
         ALU_SRL:  result_o = a_i >> shamt;
         ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
         ALU_OR:   result_o = a_i | b_i;
         ALU_AND:  result_o = a_i & b_i;
         ALU_EQ:   flag_o   = (a_i == b_i);
         ALU_NE:   flag_o   = (a_i != b_i);
         ALU_LTS:  flag_o   = lt_s;
         ALU_GES:  flag_o   = !lt_s;
         ALU_LTU:  flag_o   = lt_u;
         ALU_GEU:  flag_o   = !lt_u;
         default: begin
            result_o = '0;
            flag_o   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_ex_stage.sv
// Two-stage execute wrapper: OP register -> alu_riscv -> RES register, valid/ready on both
// sides, one op per cycle, no skid buffer (backpressure is combinational to upstream).
// Optional macro ALU_FWD_EN adds fwd_a_i/fwd_b_i to substitute the previous op's result.
module alu_ex_stage
   import alu_opcodes_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int RD_W = 5
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [ALU_OP_W-1:0] alu_op_i,
   input  logic [XLEN-1:0]     a_i,
   input  logic [XLEN-1:0]     b_i,
   input  logic [RD_W-1:0]     rd_i,
`ifdef ALU_FWD_EN
   input  logic                fwd_a_i,
   input  logic                fwd_b_i,
`endif
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [XLEN-1:0]     out_result_o,
   output logic                out_flag_o,
   output logic [RD_W-1:0]     out_rd_o
);

   // OP stage
   logic                op_valid_q,  op_valid_d;
   logic [ALU_OP_W-1:0] op_alu_op_q, op_alu_op_d;
   logic [XLEN-1:0]     op_a_q,      op_a_d;
   logic [XLEN-1:0]     op_b_q,      op_b_d;
   logic [RD_W-1:0]     op_rd_q,     op_rd_d;

   // RES stage
   logic                res_valid_q,  res_valid_d;
   logic [XLEN-1:0]     res_result_q, res_result_d;
   logic                res_flag_q,   res_flag_d;
   logic [RD_W-1:0]     res_rd_q,     res_rd_d;

   logic            res_adv;
   logic            op_adv;
   logic            accept;
   logic [XLEN-1:0] alu_result;
   logic            alu_flag;
   logic [XLEN-1:0] a_sel;
   logic [XLEN-1:0] b_sel;

   alu_riscv #(.XLEN(XLEN)) u_alu (
      .alu_op_i (op_alu_op_q),
      .a_i      (op_a_q),
      .b_i      (op_b_q),
      .result_o (alu_result),
      .flag_o   (alu_flag)
   );

   assign res_adv    = !res_valid_q || out_ready_i;
   assign op_adv     = op_valid_q && res_adv;
   assign in_ready_o = !flush_i && (!op_valid_q || res_adv);
   assign accept     = in_valid_i && in_ready_o;

`ifdef ALU_FWD_EN
   // Producer still in OP and leaving this edge -> take the live ALU output;
   // otherwise it is already registered (or drained) in RES.
   logic [XLEN-1:0] fwd_val;
   assign fwd_val = op_adv ? alu_result : res_result_q;
   assign a_sel   = fwd_a_i ? fwd_val : a_i;
   assign b_sel   = fwd_b_i ? fwd_val : b_i;
`else
   assign a_sel = a_i;
   assign b_sel = b_i;
`endif

   // next-state for both stages; flush kills valids but leaves data registers alone
   always_comb begin
      op_valid_d   = op_valid_q;
      op_alu_op_d  = op_alu_op_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      op_rd_d      = op_rd_q;
      res_valid_d  = res_valid_q;
      res_result_d = res_result_q;
      res_flag_d   = res_flag_q;
      res_rd_d     = res_rd_q;

      if (accept) begin
         op_alu_op_d = alu_op_i;
         op_a_d      = a_sel;
         op_b_d      = b_sel;
         op_rd_d     = rd_i;
      end
      if (op_adv && !flush_i) begin
         res_result_d = alu_result;
         res_flag_d   = alu_flag;
         res_rd_d     = op_rd_q;
      end

      if (flush_i) begin
         op_valid_d  = 1'b0;
         res_valid_d = 1'b0;
      end else begin
         if (accept)
            op_valid_d = 1'b1;
         else if (op_adv)
            op_valid_d = 1'b0;

         if (op_adv)
            res_valid_d = 1'b1;
         else if (res_valid_q && out_ready_i)
            res_valid_d = 1'b0;
      end
   end

   // state registers, cleared asynchronously
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         op_valid_q   <= 1'b0;
         op_alu_op_q  <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         op_rd_q      <= '0;
         res_valid_q  <= 1'b0;
         res_result_q <= '0;
         res_flag_q   <= 1'b0;
         res_rd_q     <= '0;
      end else begin
         op_valid_q   <= op_valid_d;
         op_alu_op_q  <= op_alu_op_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         op_rd_q      <= op_rd_d;
         res_valid_q  <= res_valid_d;
         res_result_q <= res_result_d;
         res_flag_q   <= res_flag_d;
         res_rd_q     <= res_rd_d;
      end
   end

   assign out_valid_o  = res_valid_q;
   assign out_result_o = res_result_q;
   assign out_flag_o   = res_flag_q;
   assign out_rd_o     = res_rd_q;

endmodule
